hazard_unit_mc: RTL

- Parametrised next-generation hazard/forwarding unit for the pipelined CPU: F, D, E, M and W stages.
- Keeps the existing behaviour: register-match forwarding, load-use stall, branch flush, and PC-write-pending stall/flush.
- Adds three things:
  - a multi-cycle multiply FSM that holds E for a parametrised latency;
  - a variable-latency data-memory wait (ready handshake) that freezes F through M;
  - saturating stall/flush performance counters.
- Sits beside the controller and datapath in the CPU top; computes all register-address matches internally.

---
 rtl/hazard_unit_mc.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding unit for the five-stage pipeline. It adds a multi-cycle multiply hold in E,
// a data-memory wait that freezes F..M, and saturating stall/flush counters.
module hazard_unit_mc #(
  parameter int REG_AW   = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              PCWrPendingF,
  input  logic              PCSrcW,
  input  logic              MulStartE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic              MulBusyE,
  output logic              MulDoneE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  // The down-counter only ever holds MUL_LAT-2, so it is sized for that value.
  localparam int CW = (MUL_LAT > 3) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mulState_t;

  mulState_t       mulState, mulStateNext;
  logic [CW-1:0]   mulCnt, mulCntNext;
  logic            memStall, ldrStall, mulStall;

  function automatic logic regMatch(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    regMatch = (a == b) && (!ZERO_REG || (a != {REG_AW{1'b0}}));
  endfunction

  // Forwarding selects; the M stage result is newer, so it wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && regMatch(WA3M, RA1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && regMatch(WA3W, RA1E)) begin
      ForwardAE = 2'b01;
    end else begin
      ForwardAE = 2'b00;
    end
    if (RegWriteM && regMatch(WA3M, RA2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && regMatch(WA3W, RA2E)) begin
      ForwardBE = 2'b01;
    end else begin
      ForwardBE = 2'b00;
    end
  end

  // Load-use and memory-wait hazard detection.
  always_comb begin
    memStall = MemReqM & ~MemReadyM;
    ldrStall = MemtoRegE & (regMatch(WA3E, RA1D) | regMatch(WA3E, RA2D));
  end

  // Multiply FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulState <= IDLE;
      mulCnt   <= CNT_ZERO;
    end else begin
      mulState <= mulStateNext;
      mulCnt   <= mulCntNext;
    end
  end

  // Multiply FSM next state; a memory wait freezes the whole FSM, including a pending start.
  always_comb begin
    mulStateNext = mulState;
    mulCntNext   = mulCnt;
    case (mulState)
      IDLE: begin
        if (MulStartE && !memStall) begin
          mulStateNext = BUSY;
          mulCntNext   = MUL_LOAD;
        end else begin
          mulStateNext = IDLE;
          mulCntNext   = mulCnt;
        end
      end
      BUSY: begin
        if (memStall) begin
          mulStateNext = BUSY;
          mulCntNext   = mulCnt;
        end else if (mulCnt != CNT_ZERO) begin
          mulStateNext = BUSY;
          mulCntNext   = mulCnt - CW'(1);
        end else begin
          mulStateNext = IDLE;
          mulCntNext   = CNT_ZERO;
        end
      end
      default: begin
        mulStateNext = IDLE;
        mulCntNext   = CNT_ZERO;
      end
    endcase
  end

  // Multiply FSM outputs.
  always_comb begin
    mulStall = 1'b0;
    MulBusyE = 1'b0;
    MulDoneE = 1'b0;
    case (mulState)
      IDLE: begin
        mulStall = MulStartE & ~memStall;
        MulBusyE = 1'b0;
        MulDoneE = 1'b0;
      end
      BUSY: begin
        mulStall = (mulCnt != CNT_ZERO);
        MulBusyE = 1'b1;
        MulDoneE = (mulCnt == CNT_ZERO) & ~memStall;
      end
      default: begin
        mulStall = 1'b0;
        MulBusyE = 1'b0;
        MulDoneE = 1'b0;
      end
    endcase
  end

  // Stall and flush steering: a memory wait freezes everything and only bubbles W.
  always_comb begin
    StallF = memStall | mulStall | ldrStall | PCWrPendingF;
    StallD = memStall | mulStall | ldrStall;
    StallE = memStall | mulStall;
    StallM = memStall;
    FlushD = ~memStall & ~mulStall & (PCWrPendingF | PCSrcW | BranchTakenE);
    FlushE = ~memStall & ~mulStall & (ldrStall | BranchTakenE);
    FlushM = ~memStall & mulStall;
    FlushW = memStall;
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= {CNT_W{1'b0}};
      FlushCnt <= {CNT_W{1'b0}};
    end else if (CntClr) begin
      StallCnt <= {CNT_W{1'b0}};
      FlushCnt <= {CNT_W{1'b0}};
    end else begin
      if (StallF && (StallCnt != CNT_MAX)) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end else begin
        StallCnt <= StallCnt;
      end
      if (FlushE && (FlushCnt != CNT_MAX)) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end else begin
        FlushCnt <= FlushCnt;
      end
    end
  end

endmodule
